// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and constants for the boot loader
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LOAD,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [3:0] WMASK_WORD = 4'b1111;
  localparam int         HDR_BYTES  = 2;

  function automatic logic accepts_bytes(input state_e s);
    return s inside {ST_HDR0, ST_HDR1, ST_LOAD, ST_CSUM};
  endfunction

  function automatic logic is_busy(input state_e s);
    return s inside {ST_HDR0, ST_HDR1, ST_LOAD, ST_WRITE, ST_CSUM};
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs little-endian payload bytes into words and keeps the payload XOR
module word_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic [7:0]  csum_q;

  // word_o already contains the byte being accepted, so the top can register a finished word on the 4th byte's edge
  always_comb begin
    word_o = word_q;
    word_o[{lane_q, 3'b000} +: 8] = byte_i;
  end

  assign word_full_o = byte_en_i & (lane_q == 2'd3);
  assign csum_o      = csum_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lane_q <= 2'd0;
      word_q <= 32'h0;
      csum_q <= 8'h00;
    end else if (clear_i) begin
      lane_q <= 2'd0;
      word_q <= 32'h0;
      csum_q <= 8'h00;
    end else if (byte_en_i) begin
      lane_q <= lane_q + 2'd1;
      word_q <= word_o;
      csum_q <= csum_q ^ byte_i;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads a checksummed image from a byte stream into SRAM, then releases the core
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int DEPTH_WORDS = 512
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_wen_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              core_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              byte_ready_q, mem_wen_q, core_reset_q, busy_q, done_q, err_q;
  logic [3:0]        mem_wmask_q;

  logic              xfer;
  logic [15:0]       n_hdr;
  logic              asm_clear, asm_en, asm_full;
  logic [31:0]       asm_word;
  logic [7:0]        asm_csum;

  assign xfer  = byte_valid_i & byte_ready_q;
  assign n_hdr = {byte_i, n_q[7:0]};

  word_assembler u_asm (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (asm_clear),
    .byte_en_i   (asm_en),
    .byte_i      (byte_i),
    .word_o      (asm_word),
    .word_full_o (asm_full),
    .csum_o      (asm_csum)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    asm_clear  = 1'b0;
    asm_en     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d    = ST_HDR0;
          word_idx_d = 16'd0;
          asm_clear  = 1'b1;
        end
      end
      ST_HDR0: begin
        if (xfer) begin
          n_d     = {8'h00, byte_i};
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          n_d = n_hdr;
          if (n_hdr > 16'(DEPTH_WORDS)) state_d = ST_ERROR;
          else if (n_hdr == 16'd0)      state_d = ST_CSUM;
          else                          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          asm_en = 1'b1;
          if (asm_full) begin
            state_d    = ST_WRITE;
            mem_addr_d = ADDR_W'({word_idx_q, 2'b00});
            mem_data_d = asm_word;
          end
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_q + 16'd1 == n_q) ? ST_CSUM : ST_LOAD;
      end
      ST_CSUM: begin
        if (xfer) state_d = (byte_i == asm_csum) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      n_q          <= 16'd0;
      word_idx_q   <= 16'd0;
      mem_addr_q   <= '0;
      mem_data_q   <= 32'h0;
      byte_ready_q <= 1'b0;
      mem_wen_q    <= 1'b1;
      mem_wmask_q  <= WMASK_WORD;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      byte_ready_q <= accepts_bytes(state_d);
      mem_wen_q    <= (state_d != ST_WRITE);
      mem_wmask_q  <= WMASK_WORD;
      core_reset_q <= (state_d == ST_DONE);
      busy_q       <= is_busy(state_d);
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERROR);
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign mem_wen_o    = mem_wen_q;
  assign mem_wmask_o  = mem_wmask_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign core_reset_o = core_reset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
